// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, ALU codes,
// FSM states and datapath mux selects.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_NONE = 4'hF
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALU_OP_ADD,
        ALU_OP_BRANCH,
        ALU_OP_RTYPE,
        ALU_OP_ITYPE
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWR,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_UPPER,
        S_ILLEGAL
    } state_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] RES_ALU_REG = 2'd0;
    localparam logic [1:0] RES_MEM     = 2'd1;
    localparam logic [1:0] RES_ALU_OUT = 2'd2;

    // BEQ/BGE/BGEU branch on zero; BNE/BLT/BLTU branch on a non-zero compare.
    function automatic logic branch_taken(input logic [2:0] func3, input logic zero);
        return zero ^ (func3[2] ^ func3[0]);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class plus func3/func7 onto an ALU control code.
import rv_ctrl_pkg::*;

module alu_decoder #(
    parameter int ALU_CTRL_W = 4
) (
    input  alu_op_e               alu_op,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    alu_ctrl_e code;
    logic      unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        code = ALU_NONE;
        case (alu_op)
            ALU_OP_ADD: code = ALU_ADD;
            ALU_OP_BRANCH: begin
                case (func3)
                    3'b000, 3'b001: code = ALU_SUB;
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        code = ALU_NONE;
                endcase
            end
            default: begin
                case (func3)
                    // Only R-type honours func7[5] here; ADDI's immediate can set that bit.
                    3'b000:  code = (alu_op == ALU_OP_RTYPE && func7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = func7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
        endcase
    end

    assign alu_control = (code == ALU_NONE) ? '1 : ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM sequencing fetch/decode/execute/memory/writeback
// over one shared memory port, with illegal-opcode and memory-timeout fault.
import rv_ctrl_pkg::*;

module multicycle_control #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op_code,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_type,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  fault
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    req_c, write_c, adr_c, ir_c, pc_c, reg_c;
    logic    timeout_hit;
    logic    fault_q;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
            logic [CNT_W-1:0] wait_cnt;

            // Any state change restarts the count, so each mem state begins at zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    wait_cnt <= '0;
                else if (state_d != state_q)
                    wait_cnt <= '0;
                else if (req_c && !mem_ready)
                    wait_cnt <= wait_cnt + 1'b1;
            end

            assign timeout_hit = (wait_cnt == CNT_LAST);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL)
                fault_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        write_c    = 1'b0;
        adr_c      = 1'b0;
        ir_c       = 1'b0;
        pc_c       = 1'b0;
        reg_c      = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_OUT;
        imm_type   = IMM_I;
        alu_op     = ALU_OP_ADD;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_c    = 1'b1;
                    pc_c    = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ILLEGAL;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_type  = (op_code == OP_JAL) ? IMM_J : IMM_B;
                case (op_code)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_type  = op_code[5] ? IMM_S : IMM_I;
                state_d   = op_code[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD, S_MEMWR: begin
                req_c   = 1'b1;
                adr_c   = 1'b1;
                write_c = (state_q == S_MEMWR);
                if (mem_ready)
                    state_d = (state_q == S_MEMWR) ? S_FETCH : S_MEMWB;
                else if (timeout_hit)
                    state_d = S_ILLEGAL;
            end
            S_MEMWB: begin
                reg_c      = 1'b1;
                result_src = RES_MEM;
                state_d    = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP_RTYPE;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_ITYPE;
                state_d   = S_ALUWB;
            end
            S_UPPER: begin
                alu_src_a = (op_code == OP_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_type  = IMM_U;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_c      = 1'b1;
                result_src = RES_ALU_REG;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_OP_BRANCH;
                result_src = RES_ALU_REG;
                if (func3 == 3'b010 || func3 == 3'b011) begin
                    state_d = S_ILLEGAL;
                end else begin
                    pc_c    = branch_taken(func3, zero);
                    state_d = S_FETCH;
                end
            end
            S_JAL: begin
                // Target was latched during DECODE; the ALU now forms old PC + 4 for the link.
                pc_c       = 1'b1;
                result_src = RES_ALU_REG;
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                state_d    = S_ALUWB;
            end
            S_JALR: begin
                pc_c       = 1'b1;
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                result_src = RES_ALU_OUT;
                state_d    = S_ALUWB;
            end
            default: begin
                state_d = S_ILLEGAL;
            end
        endcase
    end

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .alu_op      (alu_op),
        .func3       (func3),
        .func7       (func7),
        .alu_control (alu_control)
    );

    // Strobes are qualified by rst_n so an in-flight request drops the moment reset asserts.
    assign mem_req   = req_c   & rst_n;
    assign mem_write = write_c & rst_n;
    assign adr_src   = adr_c   & rst_n;
    assign ir_write  = ir_c    & rst_n;
    assign pc_write  = pc_c    & rst_n;
    assign reg_write = reg_c   & rst_n;
    assign fault     = fault_q;

endmodule
